mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM stage of the pipelined 16-bit RISC CPU, sitting between the EX/MEM register and the MEM/WB register. It passes ALU or immediate results straight through and runs load/store instructions against a handshaked data-memory port. While an access is in flight it stalls the upstream pipeline and presents a bubble to MEM/WB. It also aborts any access that exceeds a timeout and raises a sticky error flag.

## Interface
- TIMEOUT_CYCLES, 15: maximum ACCESS cycles without `dmem_ready` before abort (≥1).

- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- alu_result_in  in  16  ALU result; also the memory word address
- imm_in  in  16  immediate value
- store_data_in  in  16  store data
- result_sel_in  in  2  00 ALU, 01 IMM, 10 MEM, 11 ALU
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- reg_addr_in  in  4  destination register
- write_enable_in  in  1  register write-back requested
- stall  out  1  hold EX/MEM and earlier stages
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  16  word address, registered
- dmem_wdata  out  16  write data, registered
- dmem_ready  in  1  access complete; sampled on a clk edge while dmem_req=1
- dmem_rdata  in  16  read data, valid with dmem_ready
- result_out  out  16  to MEM/WB result_in
- reg_addr_out  out  4  to MEM/WB reg_addr_in
- write_enable_out  out  1  to MEM/WB write_enable_in
- mem_error  out  1  sticky timeout flag

## Operation
- FSM states are IDLE, ACCESS and DONE. Reset state is IDLE.
- **IDLE, non-memory instruction** (mem_read_in=0 and mem_write_in=0): purely combinational pass-through.
  - result_out = imm_in if result_sel_in=01, else alu_result_in.
  - reg_addr_out = reg_addr_in.
  - write_enable_out = in_valid & write_enable_in.
  - stall = 0.
- **IDLE, memory instruction** (in_valid and mem_read_in or mem_write_in):
  - Latch addr, wdata, we, reg_addr_in and the write-back flag. The write-back flag is write_enable_in for loads and 0 for stores.
  - If both read and write are set, treat it as a write.
  - stall = 1 and write_enable_out = 0 this cycle.
  - Next state: ACCESS. dmem_req, dmem_we, dmem_addr and dmem_wdata take effect from the next cycle.
- **ACCESS:**
  - dmem_req = 1, stall = 1, write_enable_out = 0.
  - A 4-bit wait counter increments each cycle.
  - On an edge where dmem_ready=1: capture dmem_rdata, drop dmem_req and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no ready: drop dmem_req, set mem_error, clear the write-back flag and go to DONE.
- **DONE:**
  - stall = 0, so EX/MEM advances at this cycle's edge. Inputs are ignored.
  - result_out = captured rdata for a load, or the latched address for a store.
  - reg_addr_out = latched register address.
  - write_enable_out = latched write-back flag.
  - Next state is always IDLE.
- result_sel_in=10 with no mem_read_in is treated as ALU.
- mem_error is cleared only by reset.

## Timing
- **Reset (reset_n=0), asynchronous:**
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_error and the wait counter go to 0.
  - result_out, reg_addr_out, write_enable_out and stall are forced to 0.
  - Reset during ACCESS drops dmem_req immediately and abandons the access.
- **Pass-through latency:** 0 cycles (combinational into MEM/WB).
- **Memory instruction with ready in the first ACCESS cycle:** occupies MEM for 3 cycles (IDLE-accept, ACCESS, DONE) and stalls for 2.
- **Each extra wait cycle** adds 1 stall cycle.
- **Timeout:** at most TIMEOUT_CYCLES ACCESS cycles, then DONE with write_enable_out=0.
- **dmem_ready outside ACCESS:** ignored.
- **dmem_ready on the same edge the counter hits TIMEOUT_CYCLES:** ready wins; the access completes normally and mem_error is not set.
- **Bubbles:** write_enable_out is never 1 while stall=1.

## Test plan
- **Pass-through:** ALU op with alu_result_in=0x1234, reg 3, we=1, sel=00 → same cycle result_out=0x1234, reg_addr_out=3, write_enable_out=1, stall=0. Repeat with sel=01, imm_in=0x00FF → result_out=0x00FF.
- **Load, zero wait:** load from 0x0040 into reg 5; ready=1 with rdata=0xBEEF in the first ACCESS cycle → stall high 2 cycles, dmem_addr=0x0040, dmem_we=0; DONE shows result_out=0xBEEF, reg_addr_out=5, write_enable_out=1 for one cycle.
- **Store, 3 wait cycles:** store 0xCAFE to 0x0010 → dmem_req high 4 cycles with dmem_we=1 and dmem_wdata=0xCAFE, stall high 5 cycles, DONE write_enable_out=0.
- **Timeout:** TIMEOUT_CYCLES=4, load with ready never asserted → dmem_req high exactly 4 cycles, then mem_error=1 and DONE write_enable_out=0. mem_error stays 1 through subsequent instructions until reset_n=0.
- **Reset mid-access:** assert reset_n=0 in the second ACCESS cycle → dmem_req, stall and all outputs go to 0 immediately. After release, an ALU op passes through normally.
- **Back-to-back loads:** two loads with ready=1 each → the second is accepted in the IDLE cycle right after the first's DONE. MEM/WB sees exactly two write-enable pulses, each carrying the correct data.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipelined CPU: ALU/immediate pass-through plus handshaked
// load/store against the data-memory port, with upstream stall and access timeout.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] imm_in,
    input  logic [15:0] store_data_in,
    input  logic [1:0]  result_sel_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [3:0]  reg_addr_in,
    input  logic        write_enable_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] result_out,
    output logic [3:0]  reg_addr_out,
    output logic        write_enable_out,
    output logic        mem_error
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    // Last counter value before the access is abandoned.
    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  reg_addr_q, reg_addr_d;
    logic        wb_q, wb_d;
    logic        is_load_q, is_load_d;
    logic [15:0] rdata_q, rdata_d;
    logic        dmem_req_d, dmem_we_d, mem_error_d;
    logic [15:0] dmem_addr_d, dmem_wdata_d;
    logic        mem_op;

    assign mem_op = in_valid & (mem_read_in | mem_write_in);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        reg_addr_d   = reg_addr_q;
        wb_d         = wb_q;
        is_load_d    = is_load_q;
        rdata_d      = rdata_q;
        dmem_req_d   = dmem_req;
        dmem_we_d    = dmem_we;
        dmem_addr_d  = dmem_addr;
        dmem_wdata_d = dmem_wdata;
        mem_error_d  = mem_error;

        result_out       = (result_sel_in == 2'b01) ? imm_in : alu_result_in;
        reg_addr_out     = reg_addr_in;
        write_enable_out = in_valid & write_enable_in;
        stall            = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall            = 1'b1;
                    write_enable_out = 1'b0;
                    state_d          = StAccess;
                    wait_cnt_d       = 4'd0;
                    dmem_req_d       = 1'b1;
                    // Read+write together is treated as a store.
                    dmem_we_d        = mem_write_in;
                    dmem_addr_d      = alu_result_in;
                    dmem_wdata_d     = store_data_in;
                    reg_addr_d       = reg_addr_in;
                    is_load_d        = ~mem_write_in;
                    wb_d             = ~mem_write_in & write_enable_in;
                end
            end
            StAccess: begin
                stall            = 1'b1;
                write_enable_out = 1'b0;
                // Ready takes priority over a timeout on the same edge.
                if (dmem_ready) begin
                    rdata_d    = dmem_rdata;
                    dmem_req_d = 1'b0;
                    wait_cnt_d = 4'd0;
                    state_d    = StDone;
                end else if (wait_cnt_q == TimeoutLast) begin
                    dmem_req_d  = 1'b0;
                    mem_error_d = 1'b1;
                    wb_d        = 1'b0;
                    wait_cnt_d  = 4'd0;
                    state_d     = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StDone: begin
                result_out       = is_load_q ? rdata_q : dmem_addr;
                reg_addr_out     = reg_addr_q;
                write_enable_out = wb_q;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // MEM/WB sees a clean bubble while reset is held.
        if (!reset_n) begin
            result_out       = 16'd0;
            reg_addr_out     = 4'd0;
            write_enable_out = 1'b0;
            stall            = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            reg_addr_q <= 4'd0;
            wb_q       <= 1'b0;
            is_load_q  <= 1'b0;
            rdata_q    <= 16'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 16'd0;
            dmem_wdata <= 16'd0;
            mem_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            reg_addr_q <= reg_addr_d;
            wb_q       <= wb_d;
            is_load_q  <= is_load_d;
            rdata_q    <= rdata_d;
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            dmem_addr  <= dmem_addr_d;
            dmem_wdata <= dmem_wdata_d;
            mem_error  <= mem_error_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT_CYCLES=4); inputs driven 1 unit after
// each rising edge, outputs checked 2 units after it.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] alu_result_in, imm_in, store_data_in;
    logic [1:0]  result_sel_in;
    logic        mem_read_in, mem_write_in;
    logic [3:0]  reg_addr_in;
    logic        write_enable_in;
    logic        stall, dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [15:0] dmem_rdata;
    logic [15:0] result_out;
    logic [3:0]  reg_addr_out;
    logic        write_enable_out, mem_error;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .alu_result_in(alu_result_in),
        .imm_in(imm_in), .store_data_in(store_data_in), .result_sel_in(result_sel_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_addr_in(reg_addr_in),
        .write_enable_in(write_enable_in), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .result_out(result_out),
        .reg_addr_out(reg_addr_out), .write_enable_out(write_enable_out),
        .mem_error(mem_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; alu_result_in = 0; imm_in = 0; store_data_in = 0; result_sel_in = 0;
        mem_read_in = 0; mem_write_in = 0; reg_addr_in = 0; write_enable_in = 0;
        dmem_ready = 0; dmem_rdata = 0;
    endtask

    task automatic drive_load(input logic [15:0] addr, input logic [3:0] rd);
        in_valid = 1; alu_result_in = addr; result_sel_in = 2'b10; mem_read_in = 1;
        mem_write_in = 0; reg_addr_in = rd; write_enable_in = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        drive_load(16'h0040, 4'd5);
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0h exp=0", stall); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0h exp=0", dmem_req); end
        n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0h exp=0", mem_error); end
        n_checks++; if (result_out !== 16'h0) begin n_fail++; $display("FAIL reset_result got=%0h exp=0", result_out); end
        n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0h exp=0", write_enable_out); end
        n_checks++; if (dmem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", dmem_addr); end
        step();
        reset_n = 1;
        idle_inputs();
    endtask

    task automatic test_passthrough();
        step();
        in_valid = 1; alu_result_in = 16'h1234; reg_addr_in = 4'd3; write_enable_in = 1;
        result_sel_in = 2'b00; imm_in = 16'h00FF;
        #1;
        n_checks++; if (result_out !== 16'h1234) begin n_fail++; $display("FAIL pt_alu_result got=%0h exp=1234", result_out); end
        n_checks++; if (reg_addr_out !== 4'd3) begin n_fail++; $display("FAIL pt_reg got=%0h exp=3", reg_addr_out); end
        n_checks++; if (write_enable_out !== 1'b1) begin n_fail++; $display("FAIL pt_we got=%0h exp=1", write_enable_out); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pt_stall got=%0h exp=0", stall); end
        result_sel_in = 2'b01; #1;
        n_checks++; if (result_out !== 16'h00FF) begin n_fail++; $display("FAIL pt_imm_result got=%0h exp=00ff", result_out); end
        result_sel_in = 2'b10; #1;
        n_checks++; if (result_out !== 16'h1234) begin n_fail++; $display("FAIL pt_sel10_result got=%0h exp=1234", result_out); end
        result_sel_in = 2'b11; #1;
        n_checks++; if (result_out !== 16'h1234) begin n_fail++; $display("FAIL pt_sel11_result got=%0h exp=1234", result_out); end
        in_valid = 0; #1;
        n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL pt_invalid_we got=%0h exp=0", write_enable_out); end
        idle_inputs();
    endtask

    task automatic test_load_zero_wait();
        step();
        drive_load(16'h0040, 4'd5);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_accept_stall got=%0h exp=1", stall); end
        n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL ld_accept_we got=%0h exp=0", write_enable_out); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_accept_req got=%0h exp=0", dmem_req); end
        step();
        dmem_ready = 1; dmem_rdata = 16'hBEEF;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_access_stall got=%0h exp=1", stall); end
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL ld_access_req got=%0h exp=1", dmem_req); end
        n_checks++; if (dmem_addr !== 16'h0040) begin n_fail++; $display("FAIL ld_addr got=%0h exp=0040", dmem_addr); end
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_dmem_we got=%0h exp=0", dmem_we); end
        n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL ld_access_we got=%0h exp=0", write_enable_out); end
        step();
        dmem_ready = 0; dmem_rdata = 16'h0000;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall got=%0h exp=0", stall); end
        n_checks++; if (result_out !== 16'hBEEF) begin n_fail++; $display("FAIL ld_done_result got=%0h exp=beef", result_out); end
        n_checks++; if (reg_addr_out !== 4'd5) begin n_fail++; $display("FAIL ld_done_reg got=%0h exp=5", reg_addr_out); end
        n_checks++; if (write_enable_out !== 1'b1) begin n_fail++; $display("FAIL ld_done_we got=%0h exp=1", write_enable_out); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_done_req got=%0h exp=0", dmem_req); end
        step();
        idle_inputs();
        #1;
        n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL ld_after_we got=%0h exp=0", write_enable_out); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_after_stall got=%0h exp=0", stall); end
    endtask

    // Ready arrives on the 4th ACCESS edge, the same edge the counter would time out.
    task automatic test_store_wait3();
        int stall_cycles = 0;
        step();
        in_valid = 1; alu_result_in = 16'h0010; store_data_in = 16'hCAFE; mem_write_in = 1;
        reg_addr_in = 4'd7; write_enable_in = 1; result_sel_in = 2'b00;
        #1;
        if (stall === 1'b1) stall_cycles++;
        for (int i = 0; i < 4; i++) begin
            step();
            dmem_ready = (i == 3);
            #1;
            if (stall === 1'b1) stall_cycles++;
            n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL st_req cyc=%0d got=%0h exp=1", i, dmem_req); end
            n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL st_dmem_we cyc=%0d got=%0h exp=1", i, dmem_we); end
            n_checks++; if (dmem_wdata !== 16'hCAFE) begin n_fail++; $display("FAIL st_wdata cyc=%0d got=%0h exp=cafe", i, dmem_wdata); end
            n_checks++; if (dmem_addr !== 16'h0010) begin n_fail++; $display("FAIL st_addr cyc=%0d got=%0h exp=0010", i, dmem_addr); end
        end
        step();
        dmem_ready = 0;
        #1;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if (stall_cycles !== 5) begin n_fail++; $display("FAIL st_stall_cycles got=%0d exp=5", stall_cycles); end
        n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL st_done_we got=%0h exp=0", write_enable_out); end
        n_checks++; if (result_out !== 16'h0010) begin n_fail++; $display("FAIL st_done_result got=%0h exp=0010", result_out); end
        n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL st_tie_err got=%0h exp=0", mem_error); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL st_done_req got=%0h exp=0", dmem_req); end
        step();
        idle_inputs();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        step();
        drive_load(16'h0080, 4'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            if (dmem_req === 1'b1) req_cycles++;
            if (i == 3) begin
                n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL to_early_err got=%0h exp=0", mem_error); end
            end
            if (i == 4) begin
                n_checks++; if (mem_error !== 1'b1) begin n_fail++; $display("FAIL to_err got=%0h exp=1", mem_error); end
                n_checks++; if (write_enable_out !== 1'b0) begin n_fail++; $display("FAIL to_done_we got=%0h exp=0", write_enable_out); end
                n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_done_stall got=%0h exp=0", stall); end
                idle_inputs();
                in_valid = 1; alu_result_in = 16'h7777; reg_addr_in = 4'd6; write_enable_in = 1;
            end
        end
        n_checks++; if (req_cycles !== 4) begin n_fail++; $display("FAIL to_req_cycles got=%0d exp=4", req_cycles); end
        n_checks++; if (write_enable_out !== 1'b1) begin n_fail++; $display("FAIL to_next_we got=%0h exp=1", write_enable_out); end
        n_checks++; if (mem_error !== 1'b1) begin n_fail++; $display("FAIL to_sticky_err got=%0h exp=1", mem_error); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        step();
        drive_load(16'h0020, 4'd4);
        step();
        step();
        #1;
        reset_n = 0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got=%0h exp=0", dmem_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got=%0h exp=0", stall); end
        n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got=%0h exp=0", mem_error); end
        n_checks++; if (reg_addr_out !== 4'd0) begin n_fail++; $display("FAIL rst_mid_reg got=%0h exp=0", reg_addr_out); end
        n_checks++; if (result_out !== 16'h0) begin n_fail++; $display("FAIL rst_mid_result got=%0h exp=0", result_out); end
        step();
        reset_n = 1;
        idle_inputs();
        in_valid = 1; alu_result_in = 16'h5555; reg_addr_in = 4'd9; write_enable_in = 1;
        #1;
        n_checks++; if (result_out !== 16'h5555) begin n_fail++; $display("FAIL rst_after_result got=%0h exp=5555", result_out); end
        n_checks++; if (write_enable_out !== 1'b1) begin n_fail++; $display("FAIL rst_after_we got=%0h exp=1", write_enable_out); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_after_stall got=%0h exp=0", stall); end
        idle_inputs();
    endtask

    // dmem_ready is held high throughout; it must be ignored outside ACCESS.
    task automatic test_back_to_back();
        int pulses = 0;
        logic [15:0] seen_data [2];
        logic [3:0]  seen_reg [2];
        int bubble_bad = 0;
        logic [15:0] rdata_tab [8];
        logic [2:0]  phase_tab [8];
        // phase: 1 = present load A, 2 = present load B, 0 = idle inputs
        phase_tab = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
        rdata_tab = '{16'h0BAD, 16'h1111, 16'h0BAD, 16'h0BAD, 16'h2222, 16'h0BAD, 16'h0BAD, 16'h0BAD};
        for (int c = 0; c < 8; c++) begin
            step();
            idle_inputs();
            dmem_ready = 1;
            dmem_rdata = rdata_tab[c];
            if (phase_tab[c] == 3'd1) drive_load(16'h0100, 4'd1);
            if (phase_tab[c] == 3'd2) drive_load(16'h0200, 4'd2);
            #1;
            if (c == 3) begin
                n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%0h exp=1", stall); end
            end
            if (write_enable_out === 1'b1 && stall === 1'b1) bubble_bad++;
            if (write_enable_out === 1'b1) begin
                if (pulses < 2) begin seen_data[pulses] = result_out; seen_reg[pulses] = reg_addr_out; end
                pulses++;
            end
        end
        idle_inputs();
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        n_checks++; if (bubble_bad !== 0) begin n_fail++; $display("FAIL b2b_we_during_stall got=%0d exp=0", bubble_bad); end
        if (pulses >= 2) begin
            n_checks++; if (seen_data[0] !== 16'h1111) begin n_fail++; $display("FAIL b2b_data0 got=%0h exp=1111", seen_data[0]); end
            n_checks++; if (seen_reg[0] !== 4'd1) begin n_fail++; $display("FAIL b2b_reg0 got=%0h exp=1", seen_reg[0]); end
            n_checks++; if (seen_data[1] !== 16'h2222) begin n_fail++; $display("FAIL b2b_data1 got=%0h exp=2222", seen_data[1]); end
            n_checks++; if (seen_reg[1] !== 4'd2) begin n_fail++; $display("FAIL b2b_reg1 got=%0h exp=2", seen_reg[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_zero_wait();
        test_store_wait3();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
